booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Sequential radix-4 Booth signed multiplier for the processor's multiply path.
- Sits directly upstream of the carry-lookahead adder datapath and feeds it every cycle: it generates the Booth-recoded addend and carry-in, consumes the sum, then shifts.
- Produces the low WIDTH bits of the signed product, an overflow exception, and a one-cycle ready pulse.
- Used by the execute stage, which stalls while the block is busy.

Parameters:
- WIDTH, 32, operand/result width; must be even and at least 4.
- STEPS, WIDTH/2, number of Booth iterations (derived; not overridden).

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- ctrl_MULT  input  1  start strobe; operands are sampled on any edge where it is high.
- data_operandA  input  WIDTH  multiplicand, two's complement.
- data_operandB  input  WIDTH  multiplier, two's complement.
- data_result  output  WIDTH  low WIDTH bits of A*B.
- data_exception  output  1  high if the signed product does not fit in WIDTH bits.
- data_resultRDY  output  1  one-cycle pulse when data_result/data_exception are valid.

Behaviour:
- State machine: IDLE, RUN, DONE.
  - IDLE -> RUN on ctrl_MULT.
  - RUN -> DONE when step counter reaches STEPS-1.
  - DONE -> IDLE unconditionally, or -> RUN if ctrl_MULT is high.
- Reset: state=IDLE, counter=0, product register=0. data_result=0, data_exception=0, data_resultRDY=0.
  - Reset has priority over ctrl_MULT.
  - Reset mid-operation aborts with no ready pulse.
- Product register: {U[WIDTH+1:0], L[WIDTH-1:0], q}.
  - Start edge: U=0, L=operandB, q=0, A latched into mcand, counter=0.
- RUN, each edge: recode {L[1],L[0],q}:
  - 000/111 -> 0
  - 001/010 -> +A
  - 011 -> +2A
  - 100 -> -2A
  - 101/110 -> -A
- Addend is sign-extended to WIDTH+2 bits.
  - Negative addends are formed as the inverted addend with carry-in=1.
  - U_new = U + addend (WIDTH+2 bits, carry-out discarded).
- Then {U_new,L,q} is shifted right arithmetically by 2.
  - U sign is replicated.
  - q gets the old L[1].
  - Counter increments.
- Latency: start edge at cycle k; STEPS compute edges k+1..k+STEPS.
  - data_resultRDY=1 for the single cycle following edge k+STEPS. For WIDTH=32 that is 16 cycles after the start edge.
- Completion edge (last RUN edge) registers:
  - data_result = final L.
  - data_exception = 1 unless U[WIDTH-1:0] and L[WIDTH-1] are all equal (all zeros or all ones).
- data_result and data_exception hold their values until the next completion or reset. They do not change on start.
- data_resultRDY is 0 in every cycle except the one DONE cycle.
- ctrl_MULT while in RUN restarts the operation: new operands are latched, counter=0, and no ready pulse is issued for the aborted operation.
- ctrl_MULT in the DONE cycle: the ready pulse for the old result still occurs, and the new operation starts on the same edge.
- Operand inputs are ignored except on start edges.
- Overflow cases such as most-negative * -1 set the exception; data_result is still the wrapped low bits.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Booth select codes: SEL_ZERO, SEL_POS1, SEL_POS2, SEL_NEG1, SEL_NEG2.
  - STEPS and counter width as $clog2(STEPS).
- One sub-module: booth_recode_4.
  - Inputs: 3-bit window, mcand.
  - Outputs: WIDTH+2 addend (pre-inversion) and carry-in bit.
- The accumulate uses the team's existing carry-lookahead adder widened to WIDTH+2.

Test Plan:
- A=3, B=5, single ctrl_MULT -> 16 cycles later: RDY pulse, result=0x0000000F, exception=0; RDY low all other cycles.
- A=-7, B=6 -> result=0xFFFFFFD6, exception=0; then A=-1, B=-1 -> result=0x00000001, exception=0.
- A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1; A=0x80000000, B=1 -> result=0x80000000, exception=0.
- Start 3*5, then ctrl_MULT with 7*7 five cycles later -> exactly one RDY pulse, 16 cycles after the second start, result=0x00000031.
- Start 3*5, assert reset at cycle 8 -> no RDY pulse; result=0, exception=0; a new 2*2 afterwards gives result=4 with nominal latency.

Source files
------------

// File: rtl/booth_mult_seq_pkg.sv
// Shared encodings and helpers for the sequential radix-4 Booth multiplier.
package booth_mult_seq_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_STEPS = DEF_WIDTH / 2;

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(DEF_STEPS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_POS1 = 3'd1,
    SEL_POS2 = 3'd2,
    SEL_NEG1 = 3'd3,
    SEL_NEG2 = 3'd4
  } booth_sel_e;

  // Radix-4 recoding of the {L[1], L[0], q} window.
  function automatic booth_sel_e booth_sel(input logic [2:0] window);
    booth_sel_e sel;
    case (window)
      3'b001, 3'b010: sel = SEL_POS1;
      3'b011:         sel = SEL_POS2;
      3'b100:         sel = SEL_NEG2;
      3'b101, 3'b110: sel = SEL_NEG1;
      default:        sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_recode_4.sv
// Radix-4 Booth recoder: sign-extended addend magnitude plus the negate/carry-in bit.
module booth_recode_4
  import booth_mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       window,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH+1:0] addend_c,
  output logic             cin_c
);

  booth_sel_e sel;

  assign sel = booth_sel(window);

  // Negative selections reuse the positive magnitude; the caller inverts when cin_c is set.
  always_comb begin
    addend_c = '0;
    cin_c    = 1'b0;
    case (sel)
      SEL_POS1: addend_c = {{2{mcand[WIDTH-1]}}, mcand};
      SEL_POS2: addend_c = {mcand[WIDTH-1], mcand, 1'b0};
      SEL_NEG1: begin
        addend_c = {{2{mcand[WIDTH-1]}}, mcand};
        cin_c    = 1'b1;
      end
      SEL_NEG2: begin
        addend_c = {mcand[WIDTH-1], mcand, 1'b0};
        cin_c    = 1'b1;
      end
      default: begin
        addend_c = '0;
        cin_c    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth signed multiplier: low WIDTH product bits, overflow flag, ready pulse.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned CNT_W = cnt_width(STEPS);
  localparam int unsigned AW    = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    u_q, u_d;
  logic [WIDTH-1:0] l_q, l_d;
  logic             q_q, q_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [AW-1:0]    addend;
  logic             acc_cin;
  logic [AW-1:0]    cla_a, cla_b, cla_g, cla_p, cla_sum;
  logic [AW-1:0]    u_nx;
  logic [WIDTH-1:0] l_nx;
  logic [WIDTH:0]   top_bits;
  logic             ovf;
  logic             start;

  booth_recode_4 #(.WIDTH(WIDTH)) u_recode (
    .window   ({l_q[1], l_q[0], q_q}),
    .mcand    (mcand_q),
    .addend_c (addend),
    .cin_c    (acc_cin)
  );

  // Carry-lookahead accumulate: U + (addend or its inverse) + carry-in, carry-out dropped.
  always_comb begin : cla_acc
    logic carry;
    cla_a   = u_q;
    cla_b   = addend ^ {AW{acc_cin}};
    cla_g   = cla_a & cla_b;
    cla_p   = cla_a ^ cla_b;
    cla_sum = '0;
    carry   = acc_cin;
    for (int i = 0; i < int'(AW); i++) begin
      cla_sum[i] = cla_p[i] ^ carry;
      carry      = cla_g[i] | (cla_p[i] & carry);
    end
  end

  // Arithmetic shift right by two of {U_new, L, q}; q picks up the old L[1].
  assign u_nx     = {{2{cla_sum[AW-1]}}, cla_sum[AW-1:2]};
  assign l_nx     = {cla_sum[1:0], l_q[WIDTH-1:2]};
  assign top_bits = {u_nx[WIDTH-1:0], l_nx[WIDTH-1]};
  assign ovf      = !((&top_bits) || !(|top_bits));

  assign start = ctrl_MULT && ((state_q == IDLE) || (state_q == RUN) || (state_q == DONE));

  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    u_d     = u_q;
    l_d     = l_q;
    q_d     = q_q;
    mcand_d = mcand_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;

    case (state_q)
      IDLE: if (ctrl_MULT) state_d = RUN;
      RUN: begin
        if (!ctrl_MULT) begin
          u_d   = u_nx;
          l_d   = l_nx;
          q_d   = l_q[1];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            rdy_d   = 1'b1;
            res_d   = l_nx;
            exc_d   = ovf;
          end
        end
      end
      DONE:    state_d = ctrl_MULT ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    // A start in any legal state (re)loads the operands; results are left untouched.
    if (start) begin
      state_d = RUN;
      u_d     = '0;
      l_d     = data_operandB;
      q_d     = 1'b0;
      mcand_d = data_operandA;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      u_q     <= '0;
      l_q     <= '0;
      q_q     <= 1'b0;
      mcand_q <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
      l_q     <= l_d;
      q_q     <= q_d;
      mcand_q <= mcand_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: expected products queued at start, checked on the ready pulse.
module tb_booth_mult_seq;

  localparam int unsigned WIDTH = 32;
  localparam int STEPS = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          rdy_edge;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  logic rst_q = 1'b0;
  logic [31:0] hold_res = '0;
  logic        hold_exc = 1'b0;
  logic        exp_rdy;
  exp_t        cur;

  booth_mult_seq #(.WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    edges <= edges + 1;
    rst_q <= reset;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h edge=%0d", tag, got, exp, edges);
    end
  endtask

  // Monitor: ready must pulse exactly on the modelled edge; outputs otherwise hold.
  always @(negedge clock) begin
    if (rst_q) begin
      hold_res = '0;
      hold_exc = 1'b0;
    end
    exp_rdy = (sb.size() > 0) && (sb[0].rdy_edge == edges);
    chk("rdy", 64'(data_resultRDY), 64'(exp_rdy));
    if (exp_rdy) begin
      cur      = sb.pop_front();
      hold_res = cur.res;
      hold_exc = cur.exc;
    end
    chk("result", 64'(data_result), 64'(hold_res));
    chk("exception", 64'(data_exception), 64'(hold_exc));
  end

  // Called just after a rising edge; the next edge is the start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    exp_t x;
    int e;
    e = edges + 1;
    if (sb.size() > 0 && e <= sb[sb.size()-1].rdy_edge) void'(sb.pop_back());
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    x.res      = p[31:0];
    x.exc      = (p[63:32] != {32{p[31]}});
    x.rdy_edge = e + STEPS;
    sb.push_back(x);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    wait_cyc(2);

    start_op(32'd3, 32'd5);                 wait_cyc(20);
    start_op(-32'sd7, 32'd6);               wait_cyc(20);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_cyc(20);
    start_op(32'h0001_0000, 32'h0001_0000); wait_cyc(20);
    start_op(32'h8000_0000, 32'hFFFF_FFFF); wait_cyc(20);
    start_op(32'h8000_0000, 32'd1);         wait_cyc(20);

    // Restart while running: only the second operation reports.
    start_op(32'd3, 32'd5);
    wait_cyc(4);
    start_op(32'd7, 32'd7);
    wait_cyc(20);

    // Start on the DONE cycle: old pulse still fires, new op follows.
    start_op(32'd5, 32'd6);
    wait_cyc(STEPS);
    start_op(-32'sd3, 32'd9);
    wait_cyc(20);

    for (int i = 0; i < 6; i++) begin
      start_op($urandom, (i % 2 == 0) ? 32'($urandom_range(0, 1000)) : $urandom);
      wait_cyc(18);
    end
    for (int i = 0; i < 6; i++) begin
      start_op($urandom, $urandom);
      wait_cyc($urandom_range(0, 17));
      start_op($urandom, $urandom);
      wait_cyc(20);
    end

    // Reset mid-operation aborts silently and clears the outputs.
    start_op(32'd3, 32'd5);
    wait_cyc(7);
    do_reset();
    wait_cyc(3);
    start_op(32'd2, 32'd2);
    wait_cyc(20);

    chk("drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
